operand_stager: RTL and testbench

- Sequential front end for the 2:1 operand mux in the microprocessor datapath.
- Accepts two operands serially over a valid/ready handshake and registers them as A and B.
- Then drives the mux select so operand A is presented for HOLD cycles, followed by operand B for HOLD cycles.
- Flags every presentation cycle and pulses done at the end of each pair.

---
 rtl/operand_stager.sv | 146 ++++++++++++++
 tb/tb_operand_stager.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/operand_stager.sv
// operand_stager
//   Sequential front end for the datapath 2:1 operand mux. Two operands are
//   taken serially over a valid/ready handshake and latched as A and B. The
//   mux select then shows A for HOLD cycles, followed by B for HOLD cycles.
//   Every presentation cycle is flagged, and done pulses on the last B cycle.
//
// Handshake: a word transfers on a rising clk edge where in_valid and
//   in_ready are both high. in_ready depends only on state: it is high in
//   IDLE and GET_B and low while presenting. in_valid while in_ready is low
//   is ignored, not queued.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    operand word from upstream (WIDTH bits)
//   in_valid   in_data valid this cycle
//   in_ready   stager can accept an operand this cycle
//   a_out      registered operand A (mux input A)
//   b_out      registered operand B (mux input B)
//   sel        registered mux select, 0 = A, 1 = B
//   present    mux output is meaningful this cycle
//   done       one-cycle pulse on the last B presentation cycle
//   busy       state is not IDLE
//   state_dbg  current FSM state (0 IDLE, 1 GET_B, 2 SHOW_A, 3 SHOW_B)
module operand_stager #(
  parameter int WIDTH = 2,
  parameter int HOLD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             sel,
  output logic             present,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_B  = 2'd1,
    SHOW_A = 2'd2,
    SHOW_B = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       xfer;
  logic       hold_end;

  assign xfer     = in_valid & in_ready;
  assign hold_end = (cnt == HOLD_LAST);

  // State register plus the operand, select and hold-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_out <= '0;
      b_out <= '0;
      sel   <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (xfer) a_out <= in_data;
        end
        GET_B: begin
          if (xfer) begin
            b_out <= in_data;
            sel   <= 1'b0;
            cnt   <= 4'd0;
          end
        end
        SHOW_A: begin
          if (hold_end) begin
            cnt <= 4'd0;
            sel <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SHOW_B: begin
          if (hold_end) begin
            cnt <= 4'd0;
            sel <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          cnt <= 4'd0;
        end
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (xfer) state_nx = GET_B;
      GET_B:   if (xfer) state_nx = SHOW_A;
      SHOW_A:  if (hold_end) state_nx = SHOW_B;
      SHOW_B:  if (hold_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = 1'b0;
    present  = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      GET_B: begin
        in_ready = 1'b1;
      end
      SHOW_A: begin
        present = 1'b1;
      end
      SHOW_B: begin
        present = 1'b1;
        done    = hold_end;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_operand_stager.sv
module tb_operand_stager;

  localparam int W = 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GET_B  = 2'd1;
  localparam logic [1:0] S_SHOW_A = 2'd2;
  localparam logic [1:0] S_SHOW_B = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // HOLD=2 instance
  logic [W-1:0] in_data  = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_out, b_out;
  logic         sel, present, done, busy;
  logic [1:0]   state_dbg;

  // HOLD=1 instance
  logic [W-1:0] in_data1  = '0;
  logic         in_valid1 = 1'b0;
  logic         in_ready1;
  logic [W-1:0] a_out1, b_out1;
  logic         sel1, present1, done1, busy1;
  logic [1:0]   state_dbg1;

  operand_stager #(.WIDTH(W), .HOLD(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .a_out(a_out), .b_out(b_out), .sel(sel),
    .present(present), .done(done), .busy(busy), .state_dbg(state_dbg)
  );

  operand_stager #(.WIDTH(W), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .a_out(a_out1), .b_out(b_out1), .sel(sel1),
    .present(present1), .done(done1), .busy(busy1), .state_dbg(state_dbg1)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs are changed and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bundle check of the HOLD=2 instance.
  task automatic chk_all(input string tag, input logic [1:0] st,
                         input logic rdy, input logic pres, input logic sl,
                         input logic dn, input logic [W-1:0] ea,
                         input logic [W-1:0] eb);
    chk({tag, ".state"},   8'(state_dbg), 8'(st));
    chk({tag, ".ready"},   8'(in_ready),  8'(rdy));
    chk({tag, ".present"}, 8'(present),   8'(pres));
    chk({tag, ".sel"},     8'(sel),       8'(sl));
    chk({tag, ".done"},    8'(done),      8'(dn));
    chk({tag, ".busy"},    8'(busy),      8'(st != S_IDLE));
    chk({tag, ".a"},       8'(a_out),     8'(ea));
    chk({tag, ".b"},       8'(b_out),     8'(eb));
  endtask

  task automatic chk_mux(input string tag, input logic [W-1:0] exp);
    logic [W-1:0] m;
    m = sel ? b_out : a_out;
    chk({tag, ".mux"}, 8'(m), 8'(exp));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_all("rst0", S_IDLE, 1, 0, 0, 0, 2'b00, 2'b00);
    chk("rst0.h1_state", 8'(state_dbg1), 8'(S_IDLE));

    // Basic pair, A=01 then B=10 back-to-back.
    in_valid = 1'b1; in_data = 2'b01;
    step();
    chk_all("bp_getb", S_GET_B, 1, 0, 0, 0, 2'b01, 2'b00);
    in_data = 2'b10;
    step();
    in_valid = 1'b0;
    chk_all("bp_p1", S_SHOW_A, 0, 1, 0, 0, 2'b01, 2'b10);
    chk_mux("bp_p1", 2'b01);
    step();
    chk_all("bp_p2", S_SHOW_A, 0, 1, 0, 0, 2'b01, 2'b10);
    chk_mux("bp_p2", 2'b01);
    step();
    chk_all("bp_p3", S_SHOW_B, 0, 1, 1, 0, 2'b01, 2'b10);
    chk_mux("bp_p3", 2'b10);
    step();
    chk_all("bp_p4", S_SHOW_B, 0, 1, 1, 1, 2'b01, 2'b10);
    chk_mux("bp_p4", 2'b10);
    step();
    chk_all("bp_idle", S_IDLE, 1, 0, 0, 0, 2'b01, 2'b10);

    // Stall between operands.
    in_valid = 1'b1; in_data = 2'b11;
    step();
    in_valid = 1'b0; in_data = 2'b01;
    for (int i = 0; i < 5; i++) begin
      chk_all($sformatf("stall%0d", i), S_GET_B, 1, 0, 0, 0, 2'b11, 2'b10);
      step();
    end
    chk_all("stall5", S_GET_B, 1, 0, 0, 0, 2'b11, 2'b10);
    in_valid = 1'b1; in_data = 2'b00;
    step();
    in_valid = 1'b0;
    chk_all("stall_p1", S_SHOW_A, 0, 1, 0, 0, 2'b11, 2'b00);
    step();
    step();
    step();
    chk_all("stall_p4", S_SHOW_B, 0, 1, 1, 1, 2'b11, 2'b00);
    step();
    chk_all("stall_idle", S_IDLE, 1, 0, 0, 0, 2'b11, 2'b00);

    // Backpressure: A=01, B=11, then 10 held valid through the presentation.
    in_valid = 1'b1; in_data = 2'b01;
    step();
    in_data = 2'b11;
    step();
    in_data = 2'b10;
    chk_all("bk_p1", S_SHOW_A, 0, 1, 0, 0, 2'b01, 2'b11);
    step();
    chk_all("bk_p2", S_SHOW_A, 0, 1, 0, 0, 2'b01, 2'b11);
    step();
    chk_all("bk_p3", S_SHOW_B, 0, 1, 1, 0, 2'b01, 2'b11);
    step();
    chk_all("bk_p4", S_SHOW_B, 0, 1, 1, 1, 2'b01, 2'b11);
    step();
    chk_all("bk_idle", S_IDLE, 1, 0, 0, 0, 2'b01, 2'b11);
    step();
    chk_all("bk_newa", S_GET_B, 1, 0, 0, 0, 2'b10, 2'b11);

    // Reset mid-SHOW_B, held 2 cycles.
    in_data = 2'b01;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk_all("rs_showb", S_SHOW_B, 0, 1, 1, 0, 2'b10, 2'b01);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_all("rs_after", S_IDLE, 1, 0, 0, 0, 2'b00, 2'b00);

    // Reset races a transfer in IDLE.
    rst = 1'b1; in_valid = 1'b1; in_data = 2'b01;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk_all("race", S_IDLE, 1, 0, 0, 0, 2'b00, 2'b00);
    step();
    chk_all("race_hold", S_IDLE, 1, 0, 0, 0, 2'b00, 2'b00);

    // HOLD=1 instance: A=00, B=11.
    in_valid1 = 1'b1; in_data1 = 2'b00;
    step();
    chk("h1_getb.state", 8'(state_dbg1), 8'(S_GET_B));
    in_data1 = 2'b11;
    step();
    in_valid1 = 1'b0;
    chk("h1_p1.present", 8'(present1), 8'd1);
    chk("h1_p1.sel",     8'(sel1),     8'd0);
    chk("h1_p1.done",    8'(done1),    8'd0);
    chk("h1_p1.mux",     8'(sel1 ? b_out1 : a_out1), 8'(2'b00));
    step();
    chk("h1_p2.present", 8'(present1), 8'd1);
    chk("h1_p2.sel",     8'(sel1),     8'd1);
    chk("h1_p2.done",    8'(done1),    8'd1);
    chk("h1_p2.mux",     8'(sel1 ? b_out1 : a_out1), 8'(2'b11));
    step();
    chk("h1_idle.present", 8'(present1),   8'd0);
    chk("h1_idle.state",   8'(state_dbg1), 8'(S_IDLE));
    chk("h1_idle.ready",   8'(in_ready1),  8'd1);
    chk("h1_idle.done",    8'(done1),      8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
